// File: rtl/sif.sv
// Simple register interface: NREGS host-writable registers plus a read-only
// accepted-write counter, with every accepted write forwarded one cycle later.
module sif #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int NREGS  = 16
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              xa_wr_s,
   input  logic              xa_rd_s,
   input  logic [ADDR_W-1:0] xa_addr,
   input  logic [DATA_W-1:0] xa_data_wr,
   output logic [DATA_W-1:0] xa_data_rd,
   output logic              wa_wr_s,
   output logic [ADDR_W-1:0] wa_addr,
   output logic [DATA_W-1:0] wa_data_wr
);

   localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [ADDR_W-1:0] WCNT_ADDR = ADDR_W'(NREGS);

   logic [DATA_W-1:0] regs_r [NREGS];
   logic [DATA_W-1:0] wcnt_r;
   logic [IDX_W-1:0]  idx_s;
   logic              reg_hit_s;
   logic              wr_hit_s;
   logic [DATA_W-1:0] rd_data_s;

   // Address decode and read mux; reads see pre-write state (read-before-write).
   always_comb begin
      idx_s     = xa_addr[IDX_W-1:0];
      reg_hit_s = (xa_addr < WCNT_ADDR);
      wr_hit_s  = xa_wr_s && reg_hit_s;
      if (reg_hit_s) begin
         rd_data_s = regs_r[idx_s];
      end else if (xa_addr == WCNT_ADDR) begin
         rd_data_s = wcnt_r;
      end else begin
         rd_data_s = {DATA_W{1'b0}};
      end
   end

   // Storage, write counter, forwarded-write port and registered read data.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
         wcnt_r     <= {DATA_W{1'b0}};
         xa_data_rd <= {DATA_W{1'b0}};
         wa_wr_s    <= 1'b0;
         wa_addr    <= {ADDR_W{1'b0}};
         wa_data_wr <= {DATA_W{1'b0}};
      end else begin
         wa_wr_s <= wr_hit_s;
         if (wr_hit_s) begin
            regs_r[idx_s] <= xa_data_wr;
            wcnt_r        <= wcnt_r + DATA_W'(1'b1);
            wa_addr       <= xa_addr;
            wa_data_wr    <= xa_data_wr;
         end
         if (xa_rd_s) begin
            xa_data_rd <= rd_data_s;
         end
      end
   end

endmodule

// File: tb/tb_sif.sv
// Scoreboard bench for sif: stimulus pushes expected outputs from a
// behavioural register-file model; a negedge monitor pops and compares.
module tb_sif;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int NREGS  = 16;

   logic              clk = 1'b0;
   logic              rst_b;
   logic              xa_wr_s;
   logic              xa_rd_s;
   logic [ADDR_W-1:0] xa_addr;
   logic [DATA_W-1:0] xa_data_wr;
   logic [DATA_W-1:0] xa_data_rd;
   logic              wa_wr_s;
   logic [ADDR_W-1:0] wa_addr;
   logic [DATA_W-1:0] wa_data_wr;

   always #5 clk = ~clk;

   sif #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NREGS(NREGS)) dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .xa_wr_s    (xa_wr_s),
      .xa_rd_s    (xa_rd_s),
      .xa_addr    (xa_addr),
      .xa_data_wr (xa_data_wr),
      .xa_data_rd (xa_data_rd),
      .wa_wr_s    (wa_wr_s),
      .wa_addr    (wa_addr),
      .wa_data_wr (wa_data_wr)
   );

   typedef struct {
      logic              wa;
      logic [ADDR_W-1:0] wa_a;
      logic [DATA_W-1:0] wa_d;
      logic [DATA_W-1:0] rd;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state
   logic [DATA_W-1:0] m_mem [NREGS];
   logic [DATA_W-1:0] m_cnt;
   logic [DATA_W-1:0] m_rd;
   logic [ADDR_W-1:0] m_wa_a;
   logic [DATA_W-1:0] m_wa_d;

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   // Apply one cycle of stimulus; after the edge, update the model and queue expectations.
   task automatic cyc(input logic r, input logic w, input logic rd,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      exp_t e;
      logic [DATA_W-1:0] rv;
      int ia;
      rst_b = r; xa_wr_s = w; xa_rd_s = rd; xa_addr = a; xa_data_wr = d;
      @(posedge clk);
      ia = int'(a);
      if (r) begin
         for (int i = 0; i < NREGS; i++) m_mem[i] = '0;
         m_cnt = '0; m_rd = '0; m_wa_a = '0; m_wa_d = '0;
         e.wa = 1'b0;
      end else begin
         if (ia < NREGS) rv = m_mem[ia];
         else if (ia == NREGS) rv = m_cnt;
         else rv = '0;
         if (rd) m_rd = rv;
         e.wa = w && (ia < NREGS);
         if (e.wa) begin
            m_mem[ia] = d;
            m_cnt     = m_cnt + 1;
            m_wa_a    = a;
            m_wa_d    = d;
         end
      end
      e.wa_a = m_wa_a;
      e.wa_d = m_wa_d;
      e.rd   = m_rd;
      q.push_back(e);
      #1;
   endtask

   // Monitor: one expectation per cycle, compared away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("wa_wr_s", DATA_W'(wa_wr_s), DATA_W'(e.wa));
         chk("wa_addr", DATA_W'(wa_addr), DATA_W'(e.wa_a));
         chk("wa_data_wr", wa_data_wr, e.wa_d);
         chk("xa_data_rd", xa_data_rd, e.rd);
      end
   end

   initial begin
      logic [ADDR_W-1:0] ra;
      int sel;
      rst_b = 1'b1; xa_wr_s = 1'b0; xa_rd_s = 1'b0; xa_addr = '0; xa_data_wr = '0;
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
      cyc(1'b1, 1'b1, 1'b1, 8'h02, 32'hDEAD_BEEF);   // access during reset ignored
      cyc(1'b0, 1'b0, 1'b1, 8'h03, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 8'h05, 32'hA5A5_1234);
      cyc(1'b0, 1'b0, 1'b1, 8'h05, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 8'h07, 32'h2222_2222);
      cyc(1'b0, 1'b1, 1'b1, 8'h07, 32'h1111_1111);   // read-before-write
      cyc(1'b0, 1'b0, 1'b1, 8'h07, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 8'h10, 32'hFFFF_FFFF);   // write to WCNT dropped
      cyc(1'b0, 1'b1, 1'b0, 8'h80, 32'h1234_5678);   // unmapped write dropped
      cyc(1'b0, 1'b0, 1'b1, 8'h10, 32'h0);
      cyc(1'b0, 1'b0, 1'b1, 8'h80, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 8'h00, 32'h0000_00A0);
      cyc(1'b0, 1'b1, 1'b0, 8'h01, 32'h0000_00A1);
      cyc(1'b0, 1'b1, 1'b0, 8'h02, 32'h0000_00A2);
      cyc(1'b0, 1'b0, 1'b1, 8'h10, 32'h0);
      cyc(1'b0, 1'b1, 1'b0, 8'h03, 32'h0000_0333);
      cyc(1'b0, 1'b1, 1'b0, 8'h04, 32'h0000_0444);
      cyc(1'b1, 1'b1, 1'b0, 8'h05, 32'h0000_0555);   // reset mid-burst
      cyc(1'b0, 1'b0, 1'b1, 8'h03, 32'h0);
      cyc(1'b0, 1'b0, 1'b1, 8'h10, 32'h0);
      cyc(1'b0, 1'b0, 1'b1, 8'h05, 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      for (int n = 0; n < 2000; n++) begin
         sel = int'($urandom_range(99));
         if (sel < 70) ra = ADDR_W'($urandom_range(NREGS - 1));
         else if (sel < 82) ra = ADDR_W'(NREGS);
         else ra = ADDR_W'($urandom);
         cyc(($urandom_range(99) == 0), 1'($urandom), 1'($urandom), ra, $urandom);
      end
      cyc(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
      @(negedge clk);
      #1;
      chk("queue_drained", DATA_W'(q.size()), DATA_W'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
